fiber_glb_seg_packer: RTL and testbench

Parametrised successor to the fixed 16-bit fiber-to-GLB block path. Accepts a sparse fiber token stream (data tokens plus stop/done control tokens) and emits GLB segment blocks to the global buffer: one length header followed by that fiber's values, then a final done token. Width, buffer depth and done encoding are parameters. A pass-through mode forwards tokens unmodified. Sits between a fiber_access write/read-scanner output and the GLB write port.

---
 rtl/fiber_glb_seg_packer.sv | 173 +++++++++++++++++
 tb/tb_fiber_glb_seg_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_glb_seg_packer.sv
// Packs a sparse fiber token stream into GLB segment blocks (length header, values, done),
// or forwards tokens unchanged in pass-through mode.
module fiber_glb_seg_packer #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [DATA_W-1:0] DONE_CODE = 'h100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic              seg_mode,
    input  logic [DATA_W:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [CNT_W-1:0]  seg_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] FULL     = PTR_W'(DEPTH);
    localparam logic [DATA_W:0]  DONE_TOK = {1'b1, DONE_CODE};

    typedef enum logic [1:0] {S_FILL, S_HDR, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W:0]    out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [PTR_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   seg_q, seg_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W:0]    hdr_tok;
    logic               active, in_fire, out_fire, is_ctrl, is_done;

    assign rd_word   = mem[rd_ptr_q[AW-1:0]];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q & tile_en;
    assign overflow  = ovf_q;
    assign seg_count = seg_q;

    always_comb begin
        active   = clk_en & tile_en;
        in_ready = rst_n & active & ~flush & (state_q == S_FILL)
                   & (seg_mode | ~out_valid_q | out_ready);
        in_fire  = in_valid & in_ready;
        out_fire = out_valid_q & out_ready & active;
        is_ctrl  = in_data[DATA_W];
        is_done  = is_ctrl && (in_data[DATA_W-1:0] == DONE_CODE);
        hdr_tok  = '0;
        hdr_tok[PTR_W-1:0] = cnt_q;

        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        seg_d       = seg_q;
        mem_we      = 1'b0;

        case (state_q)
            S_FILL: begin
                if (!seg_mode) begin
                    if (in_fire) begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                    end else if (out_fire) begin
                        out_valid_d = 1'b0;
                    end
                end else if (in_fire) begin
                    if (!is_ctrl) begin
                        if (cnt_q == FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            cnt_d  = cnt_q + PTR_W'(1);
                        end
                    end else if (is_done && cnt_q == '0) begin
                        out_data_d  = DONE_TOK;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        out_data_d  = hdr_tok;
                        out_valid_d = 1'b1;
                        pend_d      = is_done;
                        state_d     = S_HDR;
                    end
                end
            end
            S_HDR, S_DRAIN: begin
                if (out_fire) begin
                    if (state_q == S_HDR) seg_d = seg_q + CNT_W'(1);
                    // rd_ptr reaching cnt means the word just accepted was the last one
                    if (rd_ptr_q == cnt_q) begin
                        cnt_d    = '0;
                        rd_ptr_d = '0;
                        if (pend_q) begin
                            out_data_d = DONE_TOK;
                            state_d    = S_DONE;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = S_FILL;
                        end
                    end else begin
                        out_data_d = {1'b0, rd_word};
                        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    pend_d      = 1'b0;
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        if (flush) begin
            state_d     = S_FILL;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            rd_ptr_d    = '0;
            pend_d      = 1'b0;
            ovf_d       = 1'b0;
            seg_d       = '0;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            seg_q       <= '0;
        end else if (active || flush) begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            seg_q       <= seg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[cnt_q[AW-1:0]] <= in_data[DATA_W-1:0];
    end

endmodule

// File: tb/tb_fiber_glb_seg_packer.sv
// Scoreboard bench for fiber_glb_seg_packer: a token-level model queues expected
// GLB output as stimulus is sent; a monitor pops and compares on each output transfer.
module tb_fiber_glb_seg_packer;

    localparam int DEPTH = 8;
    localparam logic [16:0] DONE_TOK = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        tile_en = 1'b1;
    logic        seg_mode = 1'b1;
    logic [16:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic [15:0] seg_count;

    fiber_glb_seg_packer #(
        .DATA_W(16),
        .DEPTH(DEPTH),
        .CNT_W(16),
        .DONE_CODE(16'h100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .seg_mode(seg_mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_checks = 0;
    logic [16:0] exp_q[$];
    logic [15:0] m_buf[$];
    int          m_seg = 0;
    logic        m_ovf = 1'b0;
    int          rdy_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_push(input logic [16:0] tok);
        logic done;
        if (!seg_mode) begin
            exp_q.push_back(tok);
        end else if (!tok[16]) begin
            if (m_buf.size() < DEPTH) m_buf.push_back(tok[15:0]);
            else m_ovf = 1'b1;
        end else begin
            done = (tok[15:0] == 16'h100);
            if (!done || m_buf.size() > 0) begin
                exp_q.push_back({1'b0, 16'(m_buf.size())});
                foreach (m_buf[i]) exp_q.push_back({1'b0, m_buf[i]});
                m_buf.delete();
                m_seg++;
            end
            if (done) exp_q.push_back(DONE_TOK);
        end
    endtask

    task automatic send(input logic [16:0] tok);
        logic acc;
        acc = 1'b0;
        model_push(tok);
        in_data  = tok;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("in_timeout", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // out_ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // output monitor: scoreboard pop plus stall stability
    initial begin
        logic        hold_pend;
        logic [16:0] hold_data;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            hold_pend = out_valid && !out_ready && !flush;
            hold_data = out_data;
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) check("extra_out", 32'(out_data), 32'h0002_0000);
                else check("out_tok", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_data", 32'(out_data), 0);
        check("post_rst_seg", 32'(seg_count), 0);
        check("post_rst_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;

        // D5,D7,D9,S0 with header timing and N+2 turnaround, then DONE
        send(17'h00005); send(17'h00007); send(17'h00009); send(17'h10000);
        @(negedge clk);
        check("hdr_valid", 32'(out_valid), 1);
        check("hdr_data", 32'(out_data), 3);
        n = 1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("seg_turnaround", n, 5);
        @(posedge clk);
        #1;
        send(DONE_TOK);
        wait_drain();
        check("seg_count_1", 32'(seg_count), 32'(m_seg));

        // two fibers with an empty segment in between
        send(17'h00001); send(17'h10000); send(17'h10000);
        send(17'h00002); send(17'h00003); send(17'h10001); send(DONE_TOK);
        wait_drain();
        check("seg_count_2", 32'(seg_count), 32'(m_seg));

        // 8-word drain with out_ready toggling every cycle
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(17'(32'h40 + i));
        send(17'h10000);
        wait_drain();
        rdy_mode = 0;

        // overflow: DEPTH+2 data tokens, header saturates at DEPTH, flag sticky
        for (int i = 0; i < DEPTH + 2; i++) send(17'(32'h20 + i));
        send(17'h10000);
        wait_drain();
        check("ovf_set", 32'(overflow), 32'(m_ovf));
        send(17'h00004); send(17'h00006); send(DONE_TOK);
        wait_drain();
        check("ovf_sticky", 32'(overflow), 1);
        check("seg_count_3", 32'(seg_count), 32'(m_seg));

        // flush mid-DRAIN
        for (int i = 0; i < 5; i++) send(17'(32'h60 + i));
        send(17'h10000);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
        m_buf.delete();
        m_seg = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_data", 32'(out_data), 0);
        check("flush_seg", 32'(seg_count), 0);
        check("flush_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        send(17'h00008); send(17'h10000);
        wait_drain();
        check("post_flush_seg", 32'(seg_count), 32'(m_seg));

        // pass-through with random backpressure
        seg_mode = 1'b0;
        rdy_mode = 2;
        send(17'h00001); send(17'h10000); send(DONE_TOK);
        wait_drain();
        rdy_mode = 0;
        check("pt_seg", 32'(seg_count), 32'(m_seg));
        check("pt_ovf", 32'(overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
